// File: rtl/note_player_pkg.sv
// note_player_pkg
// Shared definitions for the note player block.
//   state_t        FSM encoding, also the encoding of the db_state debug output
//   CODE_SILENCE   the note code that means "no note"
//   HALF_TABLE     half-period, in 50 MHz clock cycles, of each note code
//                  (index 1..7 = C4..B4; index 0 is unused)
//   half_period()  scaled table lookup that never returns zero
package note_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] CODE_SILENCE = 3'b000;

  localparam logic [16:0] HALF_TABLE [8] = '{
    17'd0,      // silence
    17'd95556,  // C4
    17'd85131,  // D4
    17'd75843,  // E4
    17'd71586,  // F4
    17'd63776,  // G4
    17'd56818,  // A4
    17'd50619   // B4
  };

  // Half-period after the simulation speed-up shift. A result of zero would
  // stall the divider, so it is clamped to one (toggle every cycle).
  function automatic logic [16:0] half_period(input logic [2:0] code,
                                              input int unsigned shift);
    logic [16:0] h;
    h = HALF_TABLE[code] >> shift;
    if (h == 17'd0) begin
      h = 17'd1;
    end
    return h;
  endfunction

endpackage

// File: rtl/note_player_code_debouncer.sv
// code_debouncer
// Brings the asynchronous 3-bit note code into the clock domain and filters
// out short glitches.
//   clock, reset  system clock, asynchronous active-high reset
//   code_in       raw note code, asynchronous to clock
//   acc_code      synchronised code that is being accepted
//   acc_valid     high while acc_code has been stable for STABLE_CYC samples
//   acc_new       one-cycle pulse in the first cycle a code becomes valid
//
// The stability count is evaluated on its next value, so acc_valid/acc_new
// rise in the same cycle in which the STABLE_CYC-th identical sample is
// present on the synchroniser output. That keeps the total latency from an
// input change to a registered consumer at 2 + STABLE_CYC edges.
module code_debouncer
  import note_player_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] code_in,
  output logic [2:0] acc_code,
  output logic       acc_valid,
  output logic       acc_new
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYC);

  logic [2:0] sync1_q;
  logic [2:0] s_code_q;
  logic [2:0] cand_q;
  logic [7:0] stab_q;
  logic [7:0] stab_d;

  // Two-flop synchroniser on all three bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= CODE_SILENCE;
      s_code_q <= CODE_SILENCE;
    end else begin
      sync1_q  <= code_in;
      s_code_q <= sync1_q;
    end
  end

  // A changed sample restarts the count at one; an unchanged one counts up
  // and saturates so the counter never wraps back below STAB_MAX.
  always_comb begin
    stab_d = stab_q;
    if (s_code_q != cand_q) begin
      stab_d = 8'd1;
    end else if (stab_q < STAB_MAX) begin
      stab_d = stab_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand_q <= CODE_SILENCE;
      stab_q <= 8'd0;
    end else begin
      cand_q <= s_code_q;
      stab_q <= stab_d;
    end
  end

  assign acc_code  = s_code_q;
  assign acc_valid = (stab_d == STAB_MAX);
  // New only if the count was not already saturated on this same code.
  assign acc_new   = acc_valid && ((stab_q != STAB_MAX) || (s_code_q != cand_q));

endmodule

// File: rtl/note_player.sv
// note_player
// Turns the game's 3-bit note code into a square-wave tone for the buzzer.
// A note, once started, sounds for at least MIN_HOLD cycles.
//   clock       system clock, 50 MHz nominal
//   reset       asynchronous, active-high; silences the output immediately
//   code_in     note code (000 = silence, 001..111 = notes 1..7), asynchronous
//   tone        square-wave audio output
//   playing     high while a note sounds (PLAY or HOLD)
//   note_idx    code currently sounding, 000 when idle
//   note_start  one-cycle pulse when a note begins or changes
//   db_state    FSM state (state_t encoding)
//
// Handshake: the debouncer offers a code with acc_valid/acc_new; there is no
// ready back-pressure, the FSM reacts to a code only in the acc_new cycle, so
// each accepted code is an event that is consumed exactly once.
module note_player
  import note_player_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int MIN_HOLD   = 5000000,
  parameter int DIV_SHIFT  = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] code_in,
  output logic       tone,
  output logic       playing,
  output logic [2:0] note_idx,
  output logic       note_start,
  output logic [1:0] db_state
);

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  logic [2:0] acc_code;
  logic       acc_valid;
  logic       acc_new;

  code_debouncer #(
    .STABLE_CYC (STABLE_CYC)
  ) u_debouncer (
    .clock     (clock),
    .reset     (reset),
    .code_in   (code_in),
    .acc_code  (acc_code),
    .acc_valid (acc_valid),
    .acc_new   (acc_new)
  );

  state_t        state_q, state_d;
  logic [2:0]    note_q, note_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [16:0]   div_q, div_d;
  logic          tone_q, tone_d;
  logic          start_q, start_d;

  logic [16:0]   half;
  logic [HW-1:0] hold_inc;
  logic          accept;
  logic          accept_note;
  logic          accept_silence;
  logic          do_start;
  logic          do_idle;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      note_q  <= CODE_SILENCE;
      hold_q  <= '0;
      div_q   <= '0;
      tone_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
      tone_q  <= tone_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    note_d   = note_q;
    hold_d   = hold_q;
    div_d    = div_q;
    tone_d   = tone_q;
    start_d  = 1'b0;
    do_start = 1'b0;
    do_idle  = 1'b0;

    half           = half_period(note_q, DIV_SHIFT);
    hold_inc       = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + 1'b1;
    accept         = acc_valid && acc_new;
    accept_note    = accept && (acc_code != CODE_SILENCE);
    accept_silence = accept && (acc_code == CODE_SILENCE);

    // While sounding: advance the minimum-hold counter and the divider.
    if (state_q != ST_IDLE) begin
      hold_d = hold_inc;
      if (div_q >= half - 17'd1) begin
        div_d  = 17'd0;
        tone_d = ~tone_q;
      end else begin
        div_d = div_q + 17'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_note) begin
          do_start = 1'b1;
        end
      end
      ST_PLAY: begin
        if (accept_silence) begin
          if (hold_q >= HOLD_MAX) begin
            do_idle = 1'b1;
          end else begin
            state_d = ST_HOLD;
          end
        end else if (accept_note && (acc_code != note_q)) begin
          do_start = 1'b1;
        end
      end
      ST_HOLD: begin
        // A fresh note, even the same one, outranks the hold expiring.
        if (accept_note) begin
          do_start = 1'b1;
        end else if (hold_inc >= HOLD_MAX) begin
          do_idle = 1'b1;
        end
      end
      default: begin
        do_idle = 1'b1;
      end
    endcase

    if (do_start) begin
      state_d = ST_PLAY;
      note_d  = acc_code;
      hold_d  = '0;
      div_d   = 17'd0;
      tone_d  = 1'b0;
      start_d = 1'b1;
    end else if (do_idle) begin
      state_d = ST_IDLE;
      note_d  = CODE_SILENCE;
      hold_d  = '0;
      div_d   = 17'd0;
      tone_d  = 1'b0;
    end
  end

  assign tone       = tone_q;
  assign playing    = (state_q != ST_IDLE);
  assign note_idx   = note_q;
  assign note_start = start_q;
  assign db_state   = state_q;

endmodule
